// File: rtl/key_press_gen_if.sv
// Request/status bundle between game logic and the key press generator.
// Optional cancel line is present when KEY_PRESS_GEN_CANCEL_EN is defined.
interface key_press_gen_if #(
    parameter int unsigned PEND_W = 3
);
    logic              pulse;
    logic              clr_ovf;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              overflow;
`ifdef KEY_PRESS_GEN_CANCEL_EN
    logic              cancel;

    modport master (output pulse, clr_ovf, cancel, input out, busy, pend_cnt, overflow);
    modport slave  (input pulse, clr_ovf, cancel, output out, busy, pend_cnt, overflow);
`else
    modport master (output pulse, clr_ovf, input out, busy, pend_cnt, overflow);
    modport slave  (input pulse, clr_ovf, output out, busy, pend_cnt, overflow);
`endif
endinterface

// File: rtl/key_press_gen.sv
// Turns request pulses into HOLD_CYCLES-long key levels separated by GAP_CYCLES of release,
// queueing overlapping requests. Define KEY_PRESS_GEN_CANCEL_EN to add the cancel input.
module key_press_gen #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 3
) (
    input logic            clk,
    input logic            reset,
    key_press_gen_if.slave kp
);
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              started;
    logic              dec;
    logic              inc;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    // Next state, pending queue and overflow
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        started = 1'b0;
        dec     = 1'b0;
        inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (kp.pulse) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    started = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pend_q != '0) begin
                    // Queued request wins over a same-edge pulse
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    dec     = 1'b1;
                end else if (kp.pulse) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    started = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        inc = kp.pulse && !started;

        // Clear first so that a same-edge drop keeps the flag set
        if (kp.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (inc && !dec) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

`ifdef KEY_PRESS_GEN_CANCEL_EN
        // Cancel flushes the queue, discards any same-edge pulse, and cuts a press short
        if (kp.cancel) begin
            pend_d = '0;
            ovf_d  = kp.clr_ovf ? 1'b0 : ovf_q;
            case (state_q)
                ST_HOLD: begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            endcase
        end
`endif

        out_d  = (state_d == ST_HOLD);
        busy_d = (state_d != ST_IDLE) || (pend_d != '0);
    end

    assign kp.out      = out_q;
    assign kp.busy     = busy_q;
    assign kp.pend_cnt = pend_q;
    assign kp.overflow = ovf_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Scoreboard bench for key_press_gen: a per-edge reference model pushes expected outputs,
// which are popped and compared against the DUT half a cycle later.
module tb_key_press_gen;
    localparam int unsigned HOLD = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned PW   = 3;
    localparam int          QMAX = (1 << PW) - 1;

    typedef struct packed {
        logic          out;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    key_press_gen_if #(.PEND_W(PW)) kp ();

    key_press_gen #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .PEND_W     (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: phase 0 idle, 1 held, 2 gap; left = further cycles in this phase
    int m_phase = 0;
    int m_left  = 0;
    int m_pend  = 0;
    int m_ovf   = 0;
    int m_windows = 0;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic p, input logic c, input logic k);
        bit   started = 0;
        bit   used    = 0;
        exp_t x;
        case (m_phase)
            0: if (p && !k) begin m_phase = 1; m_left = HOLD - 1; started = 1; m_windows++; end
            1: begin
                if (k || m_left == 0) begin m_phase = 2; m_left = GAP - 1; end
                else m_left--;
            end
            default: begin
                if (m_left > 0) m_left--;
                else if (k) m_phase = 0;
                else if (m_pend > 0) begin m_phase = 1; m_left = HOLD - 1; used = 1; m_windows++; end
                else if (p) begin m_phase = 1; m_left = HOLD - 1; started = 1; m_windows++; end
                else m_phase = 0;
            end
        endcase
        if (c) m_ovf = 0;
        if (k) m_pend = 0;
        else if (p && !started) begin
            if (!used) begin
                if (m_pend < QMAX) m_pend++;
                else m_ovf = 1;
            end
        end else if (used) m_pend--;
        x.out  = (m_phase == 1);
        x.busy = (m_phase != 0) || (m_pend != 0);
        x.pend = PW'(m_pend);
        x.ovf  = (m_ovf != 0);
        sb.push_back(x);
    endtask

    // Drive one edge's inputs, apply the model at the edge, return at the next falling edge
    task automatic tick(input logic p, input logic c, input logic k);
        kp.pulse   = p;
        kp.clr_ovf = c;
`ifdef KEY_PRESS_GEN_CANCEL_EN
        kp.cancel  = k;
`endif
        @(posedge clk);
        model_step(p, c, k);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset: got out=%b busy=%b pend=%0d ovf=%b want all 0",
                     kp.out, kp.busy, kp.pend_cnt, kp.overflow);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        exp_t e;
        int   highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL single edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
            if (kp.out === 1'b1) highs++;
        end
        n_vec++;
        if (highs != HOLD) begin
            n_bad++;
            $display("FAIL single_width: got %0d high cycles want %0d", highs, HOLD);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   rises = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick(i < 3, 1'b0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL b2b edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
            if (kp.out === 1'b1 && prev === 1'b0) rises++;
            prev = kp.out;
        end
        n_vec++;
        if (rises != 3) begin
            n_bad++;
            $display("FAIL b2b_windows: got %0d want 3", rises);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int   rises = 0;
        int   w0    = m_windows;
        logic prev  = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick(i < 12, 1'b0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL ovf edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
            if (i == 8) begin
                n_vec++;
                if (kp.pend_cnt !== PW'(QMAX) || kp.overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_full: got pend=%0d ovf=%b want %0d/0", kp.pend_cnt, kp.overflow, QMAX);
                end
            end
            if (i == 9) begin
                n_vec++;
                if (kp.overflow !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ovf_set: got %b want 1", kp.overflow);
                end
            end
            if (kp.out === 1'b1 && prev === 1'b0) rises++;
            prev = kp.out;
        end
        n_vec++;
        if (rises != m_windows - w0 || kp.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_windows: got %0d busy=%b want %0d busy=0", rises, kp.busy, m_windows - w0);
        end
    endtask

    task automatic test_clr_ovf();
        exp_t e;
        for (int i = 0; i < 50; i++) begin
            // clear alone, then refill and clear on the same edge as a drop, then drain
            tick(i >= 2 && i <= 11, (i == 0) || (i == 11), 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL clr edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
            if (i == 0 || i == 11) begin
                n_vec++;
                if (kp.overflow !== (i == 11)) begin
                    n_bad++;
                    $display("FAIL clr_ovf edge%0d: got %b want %b", i, kp.overflow, i == 11);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, i == 0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL rmid edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
        end
        kp.pulse = 1'b0;
        reset    = 1'b0;
        #1;
        n_vec++;
        if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== 6'b0) begin
            n_bad++;
            $display("FAIL rmid_async: got out=%b busy=%b pend=%0d ovf=%b want all 0",
                     kp.out, kp.busy, kp.pend_cnt, kp.overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e || kp.out !== 1'b0) begin
                n_bad++;
                $display("FAIL rmid_after edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
        end
    endtask

`ifdef KEY_PRESS_GEN_CANCEL_EN
    task automatic test_cancel();
        exp_t e;
        int   rises = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(i < 4, 1'b0, i == 3);
            e = sb.pop_front();
            n_vec++;
            if ({kp.out, kp.busy, kp.pend_cnt, kp.overflow} !== e) begin
                n_bad++;
                $display("FAIL cancel edge%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                         kp.out, kp.busy, kp.pend_cnt, kp.overflow, e.out, e.busy, e.pend, e.ovf);
            end
            if (i == 3) begin
                n_vec++;
                if (kp.out !== 1'b0 || kp.pend_cnt !== '0) begin
                    n_bad++;
                    $display("FAIL cancel_cut: got out=%b pend=%0d want 0/0", kp.out, kp.pend_cnt);
                end
            end
            if (i > 3 && kp.out === 1'b1 && prev === 1'b0) rises++;
            prev = kp.out;
        end
        n_vec++;
        if (rises != 0 || kp.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_after: got %0d windows busy=%b want 0/0", rises, kp.busy);
        end
    endtask
`endif

    initial begin
        kp.pulse   = 1'b0;
        kp.clr_ovf = 1'b0;
`ifdef KEY_PRESS_GEN_CANCEL_EN
        kp.cancel  = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clr_ovf();
        test_reset_mid();
`ifdef KEY_PRESS_GEN_CANCEL_EN
        test_cancel();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
